key_extractor: RTL
==================

Name: key_extractor

Overview:
- Per-stage key extractor; sits directly upstream of lookup_engine in each RMT stage.
- Accepts a PHV, selects two 48b, two 32b and two 16b containers plus a 5b tag, per a config entry indexed from PHV metadata.
- Emits extract_key, key_valid and the aligned PHV to lookup_engine.
- Config table is written over a control channel.

Parameters:
- STAGE, 0, stage number; informational, no effect on logic.
- PHV_LEN, 48*8+32*8+16*8+5*20+256 (=1124), PHV width.
- KEY_LEN, 48*2+32*2+16*2+5 (=197), key width.
- KEY_CFG_W, 23, config entry width: six 3b selectors plus 5b tag.
- CFG_DEPTH, 16, number of config entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- phv_in  in  PHV_LEN  PHV from parser or previous stage.
- phv_valid_in  in  1  phv_in valid this cycle.
- extract_key  out  KEY_LEN  key to lookup_engine.
- key_valid  out  1  key and phv_out valid.
- phv_out  out  PHV_LEN  PHV aligned with extract_key.
- key_cfg_din  in  KEY_CFG_W  config entry write data.
- key_cfg_addr  in  4  config entry index.
- key_cfg_en  in  1  config write strobe.
- key_cnt  out  32  count of PHVs accepted.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- PHV layout, MSB first:
  - 48b containers 0..7 at [1123:740]; container i = [1123-48i -: 48].
  - 32b containers 0..7 at [739:484]; container i = [739-32i -: 32].
  - 16b containers 0..7 at [483:356]; container i = [483-16i -: 16].
  - Metadata at [355:0]. Config index = phv_in[259:256].
- Config entry, MSB first: {sel48_a[2:0], sel48_b, sel32_a, sel32_b, sel16_a, sel16_b, tag[4:0]}.
- Key layout, MSB first: {c48[sel48_a], c48[sel48_b], c32[sel32_a], c32[sel32_b], c16[sel16_a], c16[sel16_b], tag}.
  - Field positions: [196:149], [148:101], [100:69], [68:37], [36:21], [20:5], [4:0].
- Reset values: all config entries 0, extract_key 0, key_valid 0, phv_out 0, key_cnt 0, all pipeline registers 0.
- Pipeline: fixed 2-cycle latency, no backpressure. A new PHV may arrive every cycle.
  - S1, at the edge where phv_valid_in=1: register phv_in and its valid bit; register the config entry cfg[phv_in[259:256]].
  - S2, next edge: compute the key from the S1 registers; drive extract_key, phv_out and key_valid=1.
- Invalid cycles: when the S1 valid bit is 0, key_valid goes to 0 next cycle. extract_key and phv_out hold their last values.
- key_valid is a single-cycle pulse per accepted PHV. Back-to-back inputs give back-to-back pulses in input order.
- Config write: at a clk edge with key_cfg_en=1, cfg[key_cfg_addr] <= key_cfg_din.
  - Read-before-write: a PHV accepted at the same edge that writes its index uses the old entry.
  - A PHV accepted at the next edge uses the new entry.
- key_cnt: increments by 1 at each edge with phv_valid_in=1. Wraps 0xFFFFFFFF -> 0 with no flag.
- Reset mid-operation: in-flight PHVs are discarded; no key_valid is produced for them. Config table and key_cnt clear.
- Out-of-range indices: none possible; a 3b selector addresses all 8 containers.

Test Plan:
- Reset defaults: after reset, drive phv_in={48'hffffffffffff,1076'b0}, valid=1 for one cycle.
  - key_valid high exactly 2 cycles later.
  - extract_key[196:101] = {2{48'hffffffffffff}}; remaining bits 0; phv_out = phv_in.
- Config select: write entry 3 = {3'd1,3'd7,3'd2,3'd0,3'd5,3'd6,5'h15}.
  - Send PHV with metadata [259:256]=3 and c48[1]=48'h111122223333, c48[7]=48'h0A0B0C0D0E0F, c32[2]=32'hDEADBEEF, c32[0]=32'h12345678, c16[5]=16'hCAFE, c16[6]=16'hBEEF.
  - Key = concatenation of those six values followed by 5'h15.
- Back-to-back: three consecutive valid PHVs with indices 0, 3, 0.
  - Three consecutive key_valid pulses; keys use entries 0, 3, 0 in order.
  - key_cnt increments by 3.
- Write/read collision: key_cfg_en with addr 2 on the same edge a PHV with index 2 is accepted → key uses the old entry.
  - A PHV with index 2 on the next edge → key uses the new entry.
- Async reset mid-flight: assert rst_n=0 between S1 and S2 of a valid PHV.
  - key_valid stays 0; outputs read 0 immediately, with no clock edge.
  - key_cnt = 0; entry 3 reads back as default.
- Counter wrap: force key_cnt to 32'hFFFFFFFE and send 2 PHVs → key_cnt = 0.

Source files
------------

// File: rtl/key_extractor.sv
// key_extractor: per-stage match-key builder sitting in front of lookup_engine.
// A PHV is captured together with the config entry its metadata selects (S1).
// One cycle later the six selected containers and the tag are packed into the
// key and presented with the PHV (S2). Fixed 2-cycle latency, no backpressure.
module key_extractor #(
  parameter int STAGE     = 0,
  parameter int PHV_LEN   = 48*8 + 32*8 + 16*8 + 5*20 + 256,
  parameter int KEY_LEN   = 48*2 + 32*2 + 16*2 + 5,
  parameter int KEY_CFG_W = 23,
  parameter int CFG_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PHV_LEN-1:0]   phv_in,
  input  logic                 phv_valid_in,
  output logic [KEY_LEN-1:0]   extract_key,
  output logic                 key_valid,
  output logic [PHV_LEN-1:0]   phv_out,
  input  logic [KEY_CFG_W-1:0] key_cfg_din,
  input  logic [3:0]           key_cfg_addr,
  input  logic                 key_cfg_en,
  output logic [31:0]          key_cnt
);

  // Top bit of each container bank; container i of a bank of width w sits at
  // [top - w*i -: w].
  localparam int C48_TOP = PHV_LEN - 1;
  localparam int C32_TOP = C48_TOP - 8*48;
  localparam int C16_TOP = C32_TOP - 8*32;
  localparam int IDX_LSB = 256;

  typedef struct packed {
    logic [2:0] sel48_a;
    logic [2:0] sel48_b;
    logic [2:0] sel32_a;
    logic [2:0] sel32_b;
    logic [2:0] sel16_a;
    logic [2:0] sel16_b;
    logic [4:0] tag;
  } key_cfg_t;

  // The stage number is informational only; reject nonsense at elaboration.
  if (STAGE < 0) begin : g_stage_chk
    $error("key_extractor: STAGE must be non-negative");
  end

  logic [KEY_CFG_W-1:0] cfg_q [CFG_DEPTH];

  logic [PHV_LEN-1:0]   phv_s1_q;
  logic                 valid_s1_q;
  key_cfg_t             cfg_s1_q;

  logic [KEY_LEN-1:0]   key_d;
  logic [KEY_LEN-1:0]   extract_key_q, extract_key_d;
  logic [PHV_LEN-1:0]   phv_out_q, phv_out_d;
  logic                 key_valid_q, key_valid_d;
  logic [31:0]          cnt_q, cnt_d;

  // Config table write port; reads in S1 see the pre-write contents.
  // NOTE: the table is small and must read as zero after reset, so it is
  // built from flops with a reset rather than inferred as a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CFG_DEPTH; i++) cfg_q[i] <= '0;
    end else if (key_cfg_en) begin
      cfg_q[key_cfg_addr] <= key_cfg_din;
    end
  end

  // S1: capture the PHV and the config entry selected by its metadata.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values (this is what gives read-before-write above).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_s1_q   <= '0;
      valid_s1_q <= 1'b0;
      cfg_s1_q   <= '0;
    end else begin
      valid_s1_q <= phv_valid_in;
      if (phv_valid_in) begin
        phv_s1_q <= phv_in;
        cfg_s1_q <= key_cfg_t'(cfg_q[phv_in[IDX_LSB +: 4]]);
      end
    end
  end

  // Key assembly and S2 next-state; outputs hold across idle cycles.
  // NOTE: every signal gets a value on every path here, so no latch is inferred.
  always_comb begin
    key_d = {
      phv_s1_q[C48_TOP - 48*int'(cfg_s1_q.sel48_a) -: 48],
      phv_s1_q[C48_TOP - 48*int'(cfg_s1_q.sel48_b) -: 48],
      phv_s1_q[C32_TOP - 32*int'(cfg_s1_q.sel32_a) -: 32],
      phv_s1_q[C32_TOP - 32*int'(cfg_s1_q.sel32_b) -: 32],
      phv_s1_q[C16_TOP - 16*int'(cfg_s1_q.sel16_a) -: 16],
      phv_s1_q[C16_TOP - 16*int'(cfg_s1_q.sel16_b) -: 16],
      cfg_s1_q.tag
    };
    key_valid_d   = valid_s1_q;
    extract_key_d = extract_key_q;
    phv_out_d     = phv_out_q;
    if (valid_s1_q) begin
      extract_key_d = key_d;
      phv_out_d     = phv_s1_q;
    end
    cnt_d = cnt_q + 32'(phv_valid_in);
  end

  // S2 output registers and the accepted-PHV counter (wraps silently).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      extract_key_q <= '0;
      phv_out_q     <= '0;
      key_valid_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      extract_key_q <= extract_key_d;
      phv_out_q     <= phv_out_d;
      key_valid_q   <= key_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  assign extract_key = extract_key_q;
  assign phv_out     = phv_out_q;
  assign key_valid   = key_valid_q;
  assign key_cnt     = cnt_q;

endmodule
